// File: rtl/reset_seq.sv
// Reset sequencer: synchronised release, ordered periph/core bring-up, SW/WDT re-run.
// Optional RESET_SEQ_DBG_HOLD_EN adds dbg_hold to keep the core in reset.
module reset_seq #(
   parameter int unsigned PERIPH_DLY = 8,
   parameter int unsigned CORE_DLY   = 16,
   parameter int unsigned SW_HOLD    = 4
) (
   input  logic       clk,
   input  logic       reset_a_n,
   input  logic       sw_rst_req,
   input  logic       wdt_rst_req,
`ifdef RESET_SEQ_DBG_HOLD_EN
   input  logic       dbg_hold,
`endif
   output logic       periph_rst_n,
   output logic       core_rst_n,
   output logic       rst_done,
   output logic [1:0] rst_cause
);

   typedef enum logic [2:0] {
      ASSERT,
      P_WAIT,
      C_WAIT,
      RUN,
      HOLD
   } state_t;

   localparam logic [7:0] P_LD = 8'(PERIPH_DLY - 1);
   localparam logic [7:0] C_LD = 8'(CORE_DLY - 1);
   localparam logic [7:0] H_LD = 8'(SW_HOLD - 1);

   localparam logic [1:0] CAUSE_POR = 2'd0;
   localparam logic [1:0] CAUSE_SW  = 2'd1;
   localparam logic [1:0] CAUSE_WDT = 2'd2;

   logic [1:0] sync_q;
   logic       sync_n;
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       periph_q, periph_d;
   logic       core_q, core_d;
   logic       done_q, done_d;
   logic [1:0] cause_q, cause_d;
   logic       hold_core;

`ifdef RESET_SEQ_DBG_HOLD_EN
   assign hold_core = dbg_hold;
`else
   assign hold_core = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_a_n) begin
      if (!reset_a_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign sync_n = sync_q[1];

   always_ff @(posedge clk or negedge reset_a_n) begin
      if (!reset_a_n) begin
         state_q  <= ASSERT;
         cnt_q    <= 8'd0;
         periph_q <= 1'b0;
         core_q   <= 1'b0;
         done_q   <= 1'b0;
         cause_q  <= CAUSE_POR;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         periph_q <= periph_d;
         core_q   <= core_d;
         done_q   <= done_d;
         cause_q  <= cause_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      periph_d = periph_q;
      core_d   = core_q;
      done_d   = done_q;
      cause_d  = cause_q;
      unique case (state_q)
         ASSERT: begin
            periph_d = 1'b0;
            core_d   = 1'b0;
            done_d   = 1'b0;
            if (sync_n) begin
               state_d = P_WAIT;
               cnt_d   = P_LD;
            end
         end
         P_WAIT: begin
            if (cnt_q == 8'd0) begin
               periph_d = 1'b1;
               state_d  = C_WAIT;
               cnt_d    = C_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         C_WAIT: begin
            // at zero the counter parks until a debug hold lets go
            if (cnt_q == 8'd0) begin
               if (!hold_core) begin
                  core_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = RUN;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RUN: begin
            if (sw_rst_req || wdt_rst_req) begin
               state_d  = HOLD;
               cnt_d    = H_LD;
               periph_d = 1'b0;
               core_d   = 1'b0;
               done_d   = 1'b0;
               cause_d  = wdt_rst_req ? CAUSE_WDT : CAUSE_SW;
            end
         end
         HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = P_WAIT;
               cnt_d   = P_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d  = ASSERT;
            cnt_d    = 8'd0;
            periph_d = 1'b0;
            core_d   = 1'b0;
            done_d   = 1'b0;
         end
      endcase
   end

   assign periph_rst_n = periph_q;
   assign core_rst_n   = core_q;
   assign rst_done     = done_q;
   assign rst_cause    = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: scoreboard of expected output transitions keyed by edge number.
// Define RESET_SEQ_DBG_HOLD_EN to also exercise the dbg_hold port.
module tb_reset_seq;

   logic       clk = 1'b0;
   logic       reset_a_n;
   logic       sw_rst_req;
   logic       wdt_rst_req;
`ifdef RESET_SEQ_DBG_HOLD_EN
   logic       dbg_hold;
`endif
   logic       periph_rst_n;
   logic       core_rst_n;
   logic       rst_done;
   logic [1:0] rst_cause;

   always #5 clk = ~clk;

   reset_seq dut (
      .clk          (clk),
      .reset_a_n    (reset_a_n),
      .sw_rst_req   (sw_rst_req),
      .wdt_rst_req  (wdt_rst_req),
`ifdef RESET_SEQ_DBG_HOLD_EN
      .dbg_hold     (dbg_hold),
`endif
      .periph_rst_n (periph_rst_n),
      .core_rst_n   (core_rst_n),
      .rst_done     (rst_done),
      .rst_cause    (rst_cause)
   );

   typedef struct {
      int         e;
      logic       p;
      logic       c;
      logic       d;
      logic [1:0] cs;
   } ev_t;

   ev_t  sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   edge_no = 0;
   logic pp, pc, pd;

   task automatic tick();
      @(posedge clk);
      edge_no++;
      #1;
   endtask

   task automatic expect_ev(input int e, input logic p, input logic c,
                            input logic d, input logic [1:0] cs);
      ev_t v;
      v.e  = e;
      v.p  = p;
      v.c  = c;
      v.d  = d;
      v.cs = cs;
      sb.push_back(v);
   endtask

   task automatic run_until(input int tgt);
      ev_t v;
      while (edge_no < tgt) begin
         tick();
         checks++;
         if (core_rst_n === 1'b1 && periph_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL order edge %0d: core_rst_n=1 periph_rst_n=%b",
                     edge_no, periph_rst_n);
         end
         if ({periph_rst_n, core_rst_n, rst_done} !== {pp, pc, pd}) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected edge %0d: got p/c/d=%b%b%b",
                        edge_no, periph_rst_n, core_rst_n, rst_done);
            end else begin
               v = sb.pop_front();
               if (v.e !== edge_no || periph_rst_n !== v.p ||
                   core_rst_n !== v.c || rst_done !== v.d ||
                   rst_cause !== v.cs) begin
                  errors++;
                  $display("FAIL event: got edge %0d p/c/d=%b%b%b cause=%0d, need edge %0d p/c/d=%b%b%b cause=%0d",
                           edge_no, periph_rst_n, core_rst_n, rst_done,
                           rst_cause, v.e, v.p, v.c, v.d, v.cs);
               end
            end
            pp = periph_rst_n;
            pc = core_rst_n;
            pd = rst_done;
         end
      end
   endtask

   task automatic drain(input string name);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected events missing, next at edge %0d",
                  name, sb.size(), sb[0].e);
         sb.delete();
      end
   endtask

   task automatic pulse(input int n, input logic s, input logic w);
      run_until(n - 1);
      sw_rst_req  = s;
      wdt_rst_req = w;
      run_until(n);
      sw_rst_req  = 1'b0;
      wdt_rst_req = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_a_n = 1'b1;
      edge_no   = 0;
      pp        = 1'b0;
      pc        = 1'b0;
      pd        = 1'b0;
   endtask

   task automatic test_reset();
      reset_a_n   = 1'b0;
      sw_rst_req  = 1'b0;
      wdt_rst_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({periph_rst_n, core_rst_n, rst_done, rst_cause} !== 5'b0) begin
         errors++;
         $display("FAIL reset_state: got %b%b%b cause=%0d, need 000 cause=0",
                  periph_rst_n, core_rst_n, rst_done, rst_cause);
      end
      release_reset();
      expect_ev(11, 1, 0, 0, 0);
      expect_ev(27, 1, 1, 1, 0);
      run_until(30);
      drain("por");
   endtask

   task automatic test_sw_req();
      expect_ev(40, 0, 0, 0, 1);
      expect_ev(52, 1, 0, 0, 1);
      expect_ev(68, 1, 1, 1, 1);
      pulse(40, 1'b1, 1'b0);
      run_until(75);
      drain("sw_req");
   endtask

   task automatic test_back_to_back();
      expect_ev(80, 0, 0, 0, 2);
      expect_ev(92, 1, 0, 0, 2);
      expect_ev(108, 1, 1, 1, 2);
      pulse(80, 1'b1, 1'b1);
      run_until(115);
      drain("sw_wdt_same_edge");
   endtask

   task automatic test_ignored();
      expect_ev(120, 0, 0, 0, 1);
      expect_ev(132, 1, 0, 0, 1);
      expect_ev(148, 1, 1, 1, 1);
      pulse(120, 1'b1, 1'b0);
      pulse(122, 1'b0, 1'b1);
      pulse(126, 1'b0, 1'b1);
      pulse(140, 1'b1, 1'b1);
      run_until(155);
      drain("ignored_req");
   endtask

   task automatic test_async_reset();
      expect_ev(160, 0, 0, 0, 1);
      expect_ev(172, 1, 0, 0, 1);
      pulse(160, 1'b1, 1'b0);
      run_until(176);
      #2;
      reset_a_n = 1'b0;
      #1;
      checks++;
      if ({periph_rst_n, core_rst_n, rst_done, rst_cause} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset: got %b%b%b cause=%0d, need 000 cause=0",
                  periph_rst_n, core_rst_n, rst_done, rst_cause);
      end
      repeat (2) begin
         tick();
         checks++;
         if ({periph_rst_n, core_rst_n, rst_done, rst_cause} !== 5'b0) begin
            errors++;
            $display("FAIL reset_held: got %b%b%b cause=%0d, need 000 cause=0",
                     periph_rst_n, core_rst_n, rst_done, rst_cause);
         end
      end
      drain("async_reset_pending");
      release_reset();
      expect_ev(11, 1, 0, 0, 0);
      expect_ev(27, 1, 1, 1, 0);
      run_until(30);
      drain("por_restart");
   endtask

`ifdef RESET_SEQ_DBG_HOLD_EN
   task automatic test_dbg_hold();
      reset_a_n = 1'b0;
      dbg_hold  = 1'b1;
      repeat (2) @(posedge clk);
      release_reset();
      expect_ev(11, 1, 0, 0, 0);
      run_until(50);
      dbg_hold = 1'b0;
      expect_ev(51, 1, 1, 1, 0);
      run_until(55);
      drain("dbg_hold");
   endtask
`endif

   initial begin
`ifdef RESET_SEQ_DBG_HOLD_EN
      dbg_hold = 1'b0;
`endif
      test_reset();
      test_sw_req();
      test_back_to_back();
      test_ignored();
      test_async_reset();
`ifdef RESET_SEQ_DBG_HOLD_EN
      test_dbg_hold();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_seq.md
# reset_seq

Reset sequencer for the nanorv32 simulation platform, sitting directly downstream of the reset generator. It takes the raw board reset, synchronises its release, and releases the peripheral and core reset domains in a fixed order after programmable delays. It also re-runs the sequence on a software or watchdog reset request and records the last reset cause for the testbench.

## Interface
- PERIPH_DLY, 8: cycles from synchronised release to `periph_rst_n` high; legal range 1..255.
- CORE_DLY, 16: cycles from `periph_rst_n` high to `core_rst_n` high; legal range 1..255.
- SW_HOLD, 4: cycles both domains are held low after a request; legal range 1..255.
- clk  input  1  system clock; all flops use the posedge.
- reset_a_n  input  1  asynchronous, active-low reset.
- sw_rst_req  input  1  single-cycle software reset request, synchronous to `clk`.
- wdt_rst_req  input  1  single-cycle watchdog reset request, synchronous to `clk`.
- dbg_hold  input  1  holds the core in reset. Present only with `RESET_SEQ_DBG_HOLD_EN`.
- periph_rst_n  output  1  peripheral domain reset, active-low, registered.
- core_rst_n  output  1  core domain reset, active-low, registered.
- rst_done  output  1  high while in RUN, registered.
- rst_cause  output  2  last reset cause, registered: 0 = POR, 1 = SW, 2 = WDT.

## Operation
- 2-flop release synchroniser:
  - Asynchronously cleared by `reset_a_n`.
  - Shifts in 1 each clock edge.
  - Its output `sync_n` feeds the FSM.
- One 8-bit down-counter `cnt`.
- States and transitions:
  - ASSERT: all resets low. Leaves when `sync_n` is 1: go to P_WAIT, load `cnt = PERIPH_DLY-1`.
  - P_WAIT: decrement `cnt`. When `cnt == 0`: set `periph_rst_n` to 1, go to C_WAIT, load `cnt = CORE_DLY-1`.
  - C_WAIT: decrement `cnt`. When `cnt == 0`: set `core_rst_n` and `rst_done` to 1, go to RUN.
  - RUN: on a request, go to HOLD, clear `periph_rst_n`, `core_rst_n` and `rst_done` to 0, load `cnt = SW_HOLD-1`, update `rst_cause`.
  - HOLD: decrement `cnt`. When `cnt == 0`: go to P_WAIT, load `cnt = PERIPH_DLY-1`.
- Requests outside RUN are ignored and do not change `rst_cause`.
- Simultaneous `sw_rst_req` and `wdt_rst_req`: WDT wins, `rst_cause = 2`.
- `rst_cause` is changed only by a request accepted in RUN, or by `reset_a_n`.
- `cnt` never wraps: it is only loaded on state entry and is not decremented at 0.
- Reset values (`reset_a_n` low, effective immediately):
  - `periph_rst_n = 0`, `core_rst_n = 0`, `rst_done = 0`, `rst_cause = 0`.
  - state = ASSERT, `cnt = 0`, synchroniser = 00.
- `reset_a_n` asserted mid-sequence or in RUN: immediate asynchronous return to the reset values above. No glitch high on any output.

## Timing
- Edge 1 is the first posedge with `reset_a_n` high:
  - `sync_n` is 1 after edge 2; the FSM leaves ASSERT at edge 3.
  - `periph_rst_n` rises at edge 3+PERIPH_DLY (edge 11 with defaults).
  - `core_rst_n` and `rst_done` rise at edge 3+PERIPH_DLY+CORE_DLY (edge 27 with defaults).
- Request sampled high in RUN at edge N:
  - All three outputs fall after edge N.
  - `periph_rst_n` rises at edge N+SW_HOLD+PERIPH_DLY.
  - `core_rst_n` rises at edge N+SW_HOLD+PERIPH_DLY+CORE_DLY.
- `core_rst_n` is never high while `periph_rst_n` is low.

## Configuration
- `RESET_SEQ_DBG_HOLD_EN` defined:
  - Adds the `dbg_hold` port.
  - In C_WAIT with `cnt == 0` and `dbg_hold == 1`, the FSM stays in C_WAIT.
  - `core_rst_n` rises on the first edge that samples `dbg_hold == 0`.
  - `dbg_hold` has no effect in any other state.
- Undefined: the port is absent and C_WAIT behaves as described above.

## Test plan
- POR with defaults, `reset_a_n` released before edge 1 -> `periph_rst_n` rises at edge 11, `core_rst_n` and `rst_done` at edge 27, `rst_cause = 0`.
- `sw_rst_req` pulse at edge 40 in RUN -> outputs low after edge 40, `periph_rst_n` rises at edge 52, `core_rst_n` at edge 68, `rst_cause = 1`.
- `sw_rst_req` and `wdt_rst_req` high at the same edge in RUN -> `rst_cause = 2`, same timing as the previous case.
- `wdt_rst_req` pulse during P_WAIT -> ignored: timing unchanged, `rst_cause` unchanged.
- `reset_a_n` pulsed low during C_WAIT -> all outputs 0 immediately, `rst_cause = 0`, full POR timing restarts from the new release.
- With `RESET_SEQ_DBG_HOLD_EN`, `dbg_hold` held high until edge 50 after POR -> `periph_rst_n` rises at edge 11, `core_rst_n` at the first edge sampling `dbg_hold` low (edge 51).
